// File: rtl/mips_lsu_pkg.sv
// Shared encodings and load-extension helper for the load/store sequencer.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP, S_ERR} state_t;

  // Extends a right-aligned byte/half to 32 bits; words pass through.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] r;
    r = d;
    case (size)
      SZ_BYTE: r = uns ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
      SZ_HALF: r = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Flags misaligned, out-of-range or illegal-size requests.
module lsu_align_chk
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter bit CHECK_RANGE = 1
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err
);

  logic mis, oor;

  always_comb begin
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr[0];
      SZ_WORD: mis = |addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  assign oor = CHECK_RANGE && (|addr[31:ADDR_W]);
  assign err = mis | oor;

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: splits byte/half/word accesses into byte- or word-mode
// memory cycles and returns a registered, extended response.
module mem_access_seq
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter bit CHECK_RANGE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic              dm_bmode,
  output logic [1:0]        dm_bsel,
  input  logic [31:0]       dm_dout
);

  state_t            state, nxt;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [7:0]        lo_q;
  logic              chk_err, take, acc;
  logic [31:0]       ld_raw;

  assign req_ready  = (state == S_IDLE) & ~rst;
  assign take       = req_valid & req_ready;
  assign resp_valid = (state == S_RESP) | (state == S_ERR);
  assign acc        = (state == S_ACC0) | (state == S_ACC1);
  assign dm_we      = we_q & acc & ~rst;

  lsu_align_chk #(.ADDR_W(ADDR_W), .CHECK_RANGE(CHECK_RANGE)) u_chk (
    .addr (req_addr),
    .size (req_size),
    .err  (chk_err)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (take) nxt = chk_err ? S_ERR : S_ACC0;
      S_ACC0:  nxt = (size_q == SZ_HALF) ? S_ACC1 : S_RESP;
      S_ACC1:  nxt = S_RESP;
      default: nxt = S_IDLE;
    endcase
  end

  // Halves go out as two byte cycles: low lane in ACC0, high lane in ACC1.
  always_comb begin
    dm_addr  = '0;
    dm_din   = '0;
    dm_bmode = 1'b0;
    dm_bsel  = 2'd0;
    if (acc) begin
      dm_addr = addr_q[ADDR_W-1:2];
      case (size_q)
        SZ_WORD: dm_din = wdata_q;
        SZ_BYTE: begin
          dm_bmode = 1'b1;
          dm_bsel  = addr_q[1:0];
          dm_din   = {24'h0, wdata_q[7:0]};
        end
        default: begin
          dm_bmode = 1'b1;
          dm_bsel  = {addr_q[1], state == S_ACC1};
          dm_din   = {24'h0, (state == S_ACC1) ? wdata_q[15:8] : wdata_q[7:0]};
        end
      endcase
    end
  end

  assign ld_raw = (state == S_ACC1) ? {16'h0, dm_dout[7:0], lo_q} : dm_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
      end
      if (state == S_ACC0) lo_q <= dm_dout[7:0];
      resp_err   <= (nxt == S_ERR);
      resp_rdata <= (nxt == S_RESP && !we_q) ? load_ext(ld_raw, size_q, uns_q) : 32'h0;
    end
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Load/store sequencer between the CPU datapath and the byte-capable data memory (dm_4k interface).
- The memory supports only full-word and single-byte access. This block turns byte, halfword and word loads/stores into one or two memory cycles.
- It applies zero or sign extension, detects misaligned and out-of-range addresses, and returns a registered response through a valid/ready handshake.

Parameters:
- ADDR_W, 12, byte-address width decoded by the memory; word index is addr[ADDR_W-1:2].
- CHECK_RANGE, 1, when 1, any nonzero req_addr[31:ADDR_W] is an error.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request; high only in IDLE and rst low.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word; 3 is illegal and raises an error.
- req_unsigned  in  1  zero-extend a load (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size; valid with resp_valid.
- dm_addr  out  ADDR_W-2  word index to memory.
- dm_din  out  32  word data in word mode; {24'h0, byte} in byte mode.
- dm_we  out  1  memory write enable.
- dm_bmode  out  1  1 = byte access.
- dm_bsel  out  2  byte lane, little-endian: lane 0 = bits 7:0.
- dm_dout  in  32  combinational memory read data; sign-extended byte in bmode.

Behaviour:
- Reset values: state IDLE; req_ready 0 while rst high, then 1. resp_valid, resp_err, resp_rdata and dm_we are 0. dm_addr, dm_din, dm_bmode, dm_bsel are 0.
- Accept: a request is taken at an edge where req_valid & req_ready. All request fields are latched into registers at that edge and are not re-sampled afterwards.
- States and transitions:
  - IDLE to ERR if the request is misaligned, out of range or has size 3.
  - IDLE to ACC0 otherwise.
  - ACC0 to ACC1 for size half; ACC0 to RESP otherwise.
  - ACC1 to RESP.
  - RESP to IDLE. ERR to IDLE.
- Misalignment rule: half requires addr[0]=0; word requires addr[1:0]=0.
- Memory drive during ACC0 and ACC1 (combinational from state and latched request; 0 in other states):
  - Word: bmode 0, dm_din = wdata.
  - Byte: bmode 1, bsel = addr[1:0], dm_din[7:0] = wdata[7:0].
  - Half, ACC0: bmode 1, bsel = {addr[1],0}, din[7:0] = wdata[7:0].
  - Half, ACC1: bmode 1, bsel = {addr[1],1}, din[7:0] = wdata[15:8].
- dm_we = store & (ACC0 | ACC1) & ~rst. Each lane is written exactly once, and no write occurs on a reset edge.
- Load capture: at the ACC0 edge the low byte or word is captured from dm_dout; at the ACC1 edge the high byte is captured.
- Load extension:
  - Byte: zero-extend when unsigned, else {24{b[7]}}.
  - Half: {hi, lo} extended from bit 15 by the same rule.
  - Word: unmodified.
- Response: resp_valid = 1 for exactly the cycle in RESP or ERR. resp_rdata and resp_err are registered and held stable in that cycle, then return to 0.
- Latency, with acceptance at edge T:
  - Byte or word: resp_valid high in cycle T+2.
  - Half: T+3.
  - Error: T+1, with no dm_we pulse.
- Throughput: one request per 3 cycles (byte/word) or 4 cycles (half); req_ready stays low until IDLE.
- Reset mid-operation: at the next edge, return to IDLE. The pending response is discarded and resp_valid is never asserted for it. A half-store interrupted after ACC0 leaves the low byte written, which is acceptable.

Decomposition:
- Shared package mips_lsu_pkg:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state encodings S_IDLE, S_ACC0, S_ACC1, S_RESP, S_ERR;
  - extension helper function.
- One sub-module lsu_align_chk: combinational; inputs addr, size; outputs err.

Test Plan:
- Word store to addr 0x010 with wdata 0xDEADBEEF, then word load of 0x010:
  - one dm_we pulse with bmode 0 and dm_addr 0x004;
  - load response at T+2 with rdata 0xDEADBEEF, err 0.
- Byte store of 0x80 to 0x013, then lb and lbu of 0x013:
  - write uses bsel 3;
  - lb returns 0xFFFFFF80; lbu returns 0x00000080.
- Half store of 0xA55A to 0x022, then lh and lhu of 0x022:
  - two dm_we pulses, bsel 2 then 3, din bytes 0x5A then 0xA5;
  - lh returns 0xFFFFA55A at T+3; lhu returns 0x0000A55A.
- Misaligned word load at 0x006, half store at 0x021, size 3, and addr 0x00001000 with CHECK_RANGE=1:
  - each gives resp_err 1 at T+1;
  - no dm_we pulse; rdata 0.
- Back-to-back requests with req_valid held high:
  - only accepted when req_ready is high;
  - each request produces exactly one resp_valid pulse, in order.
- Reset asserted during ACC1 of a half store:
  - no dm_we on the reset edge;
  - no resp_valid;
  - req_ready returns to 1 the cycle after rst deasserts.
